lsu_mem_master: RTL and testbench

Load/store initiator between the MEM pipeline stage and a data memory with a request/grant/response handshake. It takes one access per MEM-stage instruction and forms word-aligned address, byte enables and lane-replicated store data. It stalls the pipeline until the memory completes, then returns sign- or zero-extended load data. It is the requesting end of the data-memory port; the memory side only answers.

---
 rtl/lsu_mem_master_pkg.sv | 22 ++
 rtl/lsu_mem_master_if.sv | 25 ++
 rtl/lsu_align.sv | 57 +++++
 rtl/lsu_mem_master.sv | 173 +++++++++++++++++
 tb/tb_lsu_mem_master.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_mem_master_pkg.sv
// Shared constants for the load/store initiator: funct3 codes, FSM states, timeout default.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lsu_mem_master_pkg;

    // RISC-V load/store width encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/lsu_mem_master_if.sv
// Data-memory port: request/grant handshake plus read-response channel.
// Latency: n/a (wiring only).
// Backpressure: master holds request fields until mem_gnt; responses cannot be stalled.
interface lsu_mem_master_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Lane steering: byte enables, store-data replication, legality check, load extract/extend.
// Latency: purely combinational.
// Backpressure: none.
module lsu_align
    import lsu_mem_master_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic        illegal,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Request side: which bytes are touched, replicated data, and whether the access is legal
    always_comb begin
        be        = 4'b0000;
        wdata_rep = st_wdata;
        illegal   = 1'b0;
        case (st_funct3)
            F3_B, F3_BU: begin
                be        = 4'b0001 << st_addr_lo;
                wdata_rep = {4{st_wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                be        = 4'b0011 << st_addr_lo;
                wdata_rep = {2{st_wdata[15:0]}};
                illegal   = st_addr_lo[0];
            end
            F3_W: begin
                be      = 4'b1111;
                illegal = |st_addr_lo;
            end
            default: illegal = 1'b1;
        endcase
    end

    // Response side: pick the addressed lane and sign/zero extend it
    always_comb begin
        lane_b  = ld_word[{ld_addr_lo, 3'b000} +: 8];
        lane_h  = ld_word[{ld_addr_lo[1], 4'b0000} +: 16];
        ld_data = ld_word;
        case (ld_funct3)
            F3_B:    ld_data = {{24{lane_b[7]}}, lane_b};
            F3_BU:   ld_data = {24'h000000, lane_b};
            F3_H:    ld_data = {{16{lane_h[15]}}, lane_h};
            F3_HU:   ld_data = {16'h0000, lane_h};
            default: ld_data = ld_word;
        endcase
    end
endmodule

// File: rtl/lsu_mem_master.sv
// MEM-stage load/store initiator to a request/grant/response data memory; optional LSU_TIMEOUT_EN abort.
// Latency: store 2 stall cycles, load 3+ stall cycles, misaligned 1 stall cycle; rsp_valid in DONE.
// Backpressure: stalls the pipeline until grant and read data arrive; memory side cannot be throttled.
module lsu_mem_master
    import lsu_mem_master_pkg::*;
#(
    parameter int ADDR_W = 32
`ifdef LSU_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall_o,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              misalign_o,
    output logic              bus_err,
    lsu_mem_master_if.master  mem
);
    state_t            state, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              mis_q;

    logic [3:0]        st_be;
    logic [31:0]       st_wdata;
    logic              illegal;
    logic [31:0]       ld_data;
    logic              timeout_hit;
    logic              capture, load_rd, clr_rd;

    lsu_align u_align (
        .st_funct3  (req_funct3),
        .st_addr_lo (req_addr[1:0]),
        .st_wdata   (req_wdata),
        .be         (st_be),
        .wdata_rep  (st_wdata),
        .illegal    (illegal),
        .ld_funct3  (f3_q),
        .ld_addr_lo (addr_q[1:0]),
        .ld_word    (mem.mem_rdata),
        .ld_data    (ld_data)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    // Next state, stall and capture strobes; grant/rvalid take priority over a coincident timeout
    always_comb begin
        state_d = state;
        stall_o = 1'b0;
        capture = 1'b0;
        load_rd = 1'b0;
        clr_rd  = 1'b0;
        case (state)
            S_IDLE: begin
                stall_o = req_valid;
                if (req_valid) begin
                    capture = 1'b1;
                    clr_rd  = illegal;
                    state_d = illegal ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                stall_o = 1'b1;
                if (mem.mem_gnt) begin
                    if (we_q) begin
                        clr_rd  = 1'b1;
                        state_d = S_DONE;
                    end else if (mem.mem_rvalid) begin
                        load_rd = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (timeout_hit) begin
                    clr_rd  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_WAIT: begin
                stall_o = 1'b1;
                if (mem.mem_rvalid) begin
                    load_rd = 1'b1;
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    clr_rd  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Access registers: captured once in IDLE so mem_* stay frozen while waiting for grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            be_q    <= 4'b0000;
            wdata_q <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            if (capture && !illegal) begin
                addr_q  <= req_addr;
                we_q    <= req_we;
                f3_q    <= req_funct3;
                be_q    <= st_be;
                wdata_q <= st_wdata;
            end
            if (capture) mis_q <= illegal;
            if (load_rd)     rdata_q <= ld_data;
            else if (clr_rd) rdata_q <= '0;
        end
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] tmo_cnt;
    logic             to_q;
    logic             to_set;

    assign timeout_hit = ((state == S_REQ) || (state == S_WAIT)) &&
                         (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign to_set      = timeout_hit &&
                         (((state == S_REQ)  && !mem.mem_gnt) ||
                          ((state == S_WAIT) && !mem.mem_rvalid));

    // Wait counter: restarts on every state change, counts cycles spent in REQ/WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                   tmo_cnt <= '0;
        else if (state_d != state)                    tmo_cnt <= '0;
        else if ((state == S_REQ) || (state == S_WAIT)) tmo_cnt <= tmo_cnt + CNT_W'(1);
    end

    // Remember that DONE was reached by abort rather than completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              to_q <= 1'b0;
        else if (state == S_IDLE) to_q <= 1'b0;
        else if (to_set)          to_q <= 1'b1;
    end

    assign bus_err = (state == S_DONE) && to_q;
`else
    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
`endif

    assign rsp_valid      = (state == S_DONE);
    assign misalign_o     = (state == S_DONE) && mis_q;
    assign rsp_rdata      = rdata_q;
    assign mem.mem_req    = (state == S_REQ);
    assign mem.mem_we     = we_q;
    assign mem.mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem.mem_be     = be_q;
    assign mem.mem_wdata  = wdata_q;
endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: vector table plus hand-written multi-cycle sequences.
module tb_lsu_mem_master;
    import lsu_mem_master_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        stall_o, rsp_valid, misalign_o, bus_err;
    logic [31:0] rsp_rdata;

    always #5 clk = ~clk;

    lsu_mem_master_if #(.ADDR_W(32)) mif ();

    lsu_mem_master #(
        .ADDR_W(32)
`ifdef LSU_TIMEOUT_EN
        , .TIMEOUT_CYCLES(4)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall_o    (stall_o),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .misalign_o (misalign_o),
        .bus_err    (bus_err),
        .mem        (mif.master)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: grant after gnt_delay REQ cycles, read data same cycle or one cycle later
    int          gnt_delay = 0;
    bit          rv_same = 0, rv_never = 0, resp_manual = 0, force_rv = 0, pend_rv = 0;
    int          req_cnt = 0;
    logic [31:0] mem_word = 32'h0;

    always @(negedge clk) begin
        mif.mem_rdata = mem_word;
        if (!rst_n || resp_manual) begin
            mif.mem_gnt    = 1'b0;
            mif.mem_rvalid = force_rv;
            pend_rv        = 0;
            req_cnt        = 0;
        end else begin
            mif.mem_gnt    = 1'b0;
            mif.mem_rvalid = pend_rv;
            pend_rv        = 0;
            if (mif.mem_req) begin
                if (req_cnt >= gnt_delay) begin
                    mif.mem_gnt = 1'b1;
                    req_cnt     = 0;
                    if (!mif.mem_we && !rv_never) begin
                        if (rv_same) mif.mem_rvalid = 1'b1;
                        else         pend_rv = 1;
                    end
                end else begin
                    req_cnt++;
                end
            end else begin
                req_cnt = 0;
            end
        end
    end

    // Observations from one access
    int          r_stalls;
    bit          r_done, r_rsp, r_mis, r_err, r_done_stall, r_req, r_stable, r_we;
    logic [31:0] r_rdata, r_addr, r_wdata;
    logic [3:0]  r_be;

    // Present one access (called just after a rising edge) and watch it through DONE
    task automatic run_access(input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        r_stalls = 0; r_done = 0; r_rsp = 0; r_mis = 0; r_err = 0; r_done_stall = 1;
        r_req = 0; r_stable = 1; r_we = 0; r_rdata = 'x; r_addr = 'x; r_wdata = 'x; r_be = 'x;
        #1;
        if (stall_o) r_stalls++;
        for (int c = 0; c < 60 && !r_done; c++) begin
            @(posedge clk); #1;
            if (rsp_valid || misalign_o) begin
                r_done = 1; r_rsp = rsp_valid; r_mis = misalign_o; r_err = bus_err;
                r_done_stall = stall_o; r_rdata = rsp_rdata;
            end else begin
                if (stall_o) r_stalls++;
                if (mif.mem_req) begin
                    if (!r_req) begin
                        r_be = mif.mem_be; r_addr = mif.mem_addr;
                        r_wdata = mif.mem_wdata; r_we = mif.mem_we;
                    end else if ({r_be, r_addr, r_wdata, r_we} !==
                                 {mif.mem_be, mif.mem_addr, mif.mem_wdata, mif.mem_we}) begin
                        r_stable = 0;
                    end
                    r_req = 1;
                end
            end
        end
        req_valid = 1'b0;
        check("access_completed", 32'(r_done), 32'd1);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] word;
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [31:0] rdata;
        logic        mis;
        int          stalls;
    } vec_t;

    vec_t vecs[13];

    initial begin
        //           we  f3    addr   wdata          word           be       maddr  mwdata         rdata          mis stalls
        vecs[0]  = '{1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0,         4'b1111, 32'h10, 32'hDEADBEEF, 32'h0,         0, 2};
        vecs[1]  = '{0, F3_B,  32'h13, 32'h0,        32'h80FF0000,  4'b1000, 32'h10, 32'h0,        32'hFFFFFF80,  0, 3};
        vecs[2]  = '{0, F3_BU, 32'h13, 32'h0,        32'h80FF0000,  4'b1000, 32'h10, 32'h0,        32'h00000080,  0, 3};
        vecs[3]  = '{0, F3_W,  32'h06, 32'h0,        32'h0,         4'b0000, 32'h0,  32'h0,        32'h0,         1, 1};
        vecs[4]  = '{0, F3_H,  32'h02, 32'h0,        32'h80017FFF,  4'b1100, 32'h0,  32'h0,        32'hFFFF8001,  0, 3};
        vecs[5]  = '{1, F3_H,  32'h22, 32'h1234ABCD, 32'h0,         4'b1100, 32'h20, 32'hABCDABCD, 32'h0,         0, 2};
        vecs[6]  = '{0, F3_HU, 32'h02, 32'h0,        32'h80017FFF,  4'b1100, 32'h0,  32'h0,        32'h00008001,  0, 3};
        vecs[7]  = '{0, 3'b011,32'h00, 32'h0,        32'h0,         4'b0000, 32'h0,  32'h0,        32'h0,         1, 1};
        vecs[8]  = '{1, F3_B,  32'h01, 32'h00000055, 32'h0,         4'b0010, 32'h0,  32'h55555555, 32'h0,         0, 2};
        vecs[9]  = '{0, F3_W,  32'h08, 32'h0,        32'hCAFEF00D,  4'b1111, 32'h08, 32'h0,        32'hCAFEF00D,  0, 3};
        vecs[10] = '{0, F3_B,  32'h00, 32'h0,        32'h0000007F,  4'b0001, 32'h0,  32'h0,        32'h0000007F,  0, 3};
        vecs[11] = '{0, F3_H,  32'h01, 32'h0,        32'h0,         4'b0000, 32'h0,  32'h0,        32'h0,         1, 1};
        vecs[12] = '{1, F3_B,  32'h03, 32'h000000A5, 32'h0,         4'b1000, 32'h0,  32'hA5A5A5A5, 32'h0,         0, 2};

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctrl", 32'({stall_o, rsp_valid, misalign_o, bus_err, mif.mem_req, mif.mem_we, mif.mem_be}), 32'h0);
        check("reset_rdata", rsp_rdata, 32'h0);
        check("reset_addr", mif.mem_addr, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            mem_word = vecs[i].word;
            run_access(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
            check($sformatf("v%0d_stalls", i), 32'(r_stalls), 32'(vecs[i].stalls));
            check($sformatf("v%0d_rsp", i), 32'(r_rsp), 32'd1);
            check($sformatf("v%0d_mis", i), 32'(r_mis), 32'(vecs[i].mis));
            check($sformatf("v%0d_buserr", i), 32'(r_err), 32'd0);
            check($sformatf("v%0d_done_stall", i), 32'(r_done_stall), 32'd0);
            check($sformatf("v%0d_rdata", i), r_rdata, vecs[i].rdata);
            check($sformatf("v%0d_req_seen", i), 32'(r_req), 32'(!vecs[i].mis));
            if (!vecs[i].mis) begin
                check($sformatf("v%0d_be", i), 32'(r_be), 32'(vecs[i].be));
                check($sformatf("v%0d_addr", i), r_addr, vecs[i].maddr);
                check($sformatf("v%0d_wdata", i), r_wdata, vecs[i].mwdata);
                check($sformatf("v%0d_we", i), 32'(r_we), 32'(vecs[i].we));
                check($sformatf("v%0d_stable", i), 32'(r_stable), 32'd1);
            end
            @(posedge clk); #1;
            check($sformatf("v%0d_pulse_end", i), 32'({rsp_valid, misalign_o}), 32'd0);
            check($sformatf("v%0d_rdata_hold", i), rsp_rdata, vecs[i].rdata);
        end

        // LH with grant held off three cycles and read data alongside the grant
        gnt_delay = 3; rv_same = 1; mem_word = 32'h12348765;
        run_access(1'b0, F3_H, 32'h4, 32'h0);
        check("lh_delay_stalls", 32'(r_stalls), 32'd5);
        check("lh_delay_rdata", r_rdata, 32'hFFFF8765);
        check("lh_delay_stable", 32'(r_stable), 32'd1);
        check("lh_delay_addr", r_addr, 32'h4);
        check("lh_delay_be", 32'(r_be), 32'h3);
        gnt_delay = 0; rv_same = 0;
        @(posedge clk); #1;

        // Reset while waiting for read data; the late rvalid must be ignored
        rv_never = 1;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h40; req_wdata = 32'hFFFF0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("wait_state_stall", 32'({stall_o, mif.mem_req}), 32'b10);
        rst_n = 1'b0; req_valid = 1'b0;
        #1;
        check("midrst_ctrl", 32'({stall_o, rsp_valid, misalign_o, bus_err, mif.mem_req, mif.mem_we, mif.mem_be}), 32'h0);
        check("midrst_rdata", rsp_rdata, 32'h0);
        check("midrst_addr", mif.mem_addr, 32'h0);
        check("midrst_wdata", mif.mem_wdata, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1; resp_manual = 1; force_rv = 1;
        @(posedge clk); #1;
        force_rv = 0;
        begin
            bit seen = 0;
            for (int c = 0; c < 4; c++) begin
                @(posedge clk); #1;
                if (rsp_valid || stall_o || mif.mem_req) seen = 1;
            end
            check("late_rvalid_ignored", 32'(seen), 32'd0);
        end
        resp_manual = 0; rv_never = 0;

`ifdef LSU_TIMEOUT_EN
        // No grant ever: abort after four REQ cycles
        gnt_delay = 1000;
        run_access(1'b1, F3_W, 32'h80, 32'h1);
        check("tmo_buserr", 32'(r_err), 32'd1);
        check("tmo_rsp", 32'(r_rsp), 32'd1);
        check("tmo_stalls", 32'(r_stalls), 32'd5);
        check("tmo_rdata", r_rdata, 32'h0);
        @(posedge clk); #1;
        check("tmo_pulse_end", 32'({bus_err, rsp_valid, mif.mem_req}), 32'd0);
        gnt_delay = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
